// File: rtl/conv_filter_bank.sv
// Multi-channel convolution accumulator: each accepted beat adds a TAPS-wide dot
// product into a saturating per-channel accumulator, framed by a start/len command.
module conv_filter_bank #(
    parameter int NCH   = 2,
    parameter int TAPS  = 4,
    parameter int ACT_W = 13,
    parameter int W_W   = 8,
    parameter int OUT_W = 28,
    parameter int LEN_W = 16
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    input  logic                      relu_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAPS*ACT_W-1:0]     act,
    input  logic [NCH*TAPS*W_W-1:0]   wgt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCH*OUT_W-1:0]      out,
    output logic [NCH-1:0]            sat,
    output logic                      busy
);

    // Full-precision dot-product width, and a sum width wide enough that
    // acc + dot product can never wrap before the clamp compares it.
    localparam int SUM_W = ACT_W + W_W + $clog2(TAPS);
    localparam int EXT_W = ((OUT_W > SUM_W) ? OUT_W : SUM_W) + 1;
    localparam logic signed [EXT_W-1:0] MAXV = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MINV = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [LEN_W-1:0]         count_q, count_d;
    logic                     relu_q, relu_d;
    logic [NCH-1:0]           sat_q, sat_d;
    logic signed [OUT_W-1:0]  acc_q [NCH];
    logic signed [OUT_W-1:0]  acc_d [NCH];
    logic signed [SUM_W-1:0]  sum   [NCH];
    logic signed [EXT_W-1:0]  ext   [NCH];
    logic                     beat;

    assign beat = (state_q == ACC) && in_valid;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            count_q <= '0;
            relu_q  <= 1'b0;
            sat_q   <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            relu_q  <= relu_d;
            sat_q   <= sat_d;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (len == '0) ? DONE : ACC;
            ACC:  if (beat && count_q == LEN_W'(1)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            sum[c] = '0;
            for (int t = 0; t < TAPS; t++) begin
                sum[c] = sum[c] + (SUM_W'($signed(act[t*ACT_W +: ACT_W])) *
                                   SUM_W'($signed(wgt[(c*TAPS+t)*W_W +: W_W])));
            end
        end
    end

    // Accumulate with clamping; once clamped, later beats continue from the rail.
    always_comb begin
        count_d = count_q;
        relu_d  = relu_q;
        sat_d   = sat_q;
        for (int c = 0; c < NCH; c++) begin
            acc_d[c] = acc_q[c];
            ext[c]   = EXT_W'(acc_q[c]) + EXT_W'(sum[c]);
        end
        if (state_q == IDLE && start) begin
            count_d = len;
            relu_d  = relu_en;
            sat_d   = '0;
            for (int c = 0; c < NCH; c++) begin
                acc_d[c] = '0;
            end
        end else if (beat) begin
            count_d = count_q - LEN_W'(1);
            for (int c = 0; c < NCH; c++) begin
                if (ext[c] > MAXV) begin
                    acc_d[c] = MAXV[OUT_W-1:0];
                    sat_d[c] = 1'b1;
                end else if (ext[c] < MINV) begin
                    acc_d[c] = MINV[OUT_W-1:0];
                    sat_d[c] = 1'b1;
                end else begin
                    acc_d[c] = ext[c][OUT_W-1:0];
                end
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ACC);
        out_valid = (state_q == DONE);
        busy      = (state_q == ACC) || (state_q == DONE);
        sat       = sat_q;
        out       = '0;
        for (int c = 0; c < NCH; c++) begin
            out[c*OUT_W +: OUT_W] = (relu_q && acc_q[c][OUT_W-1]) ? '0 : acc_q[c];
        end
    end

endmodule

// File: tb/tb_conv_filter_bank.sv
// Self-checking bench for conv_filter_bank: table of runs scored through an
// expected-result queue, plus hand-written reset-mid-run and idle checks.
module tb_conv_filter_bank;

    localparam int NCH   = 2;
    localparam int TAPS  = 4;
    localparam int ACT_W = 13;
    localparam int W_W   = 8;
    localparam int OUT_W = 22;
    localparam int LEN_W = 16;

    logic                    clk = 1'b0;
    logic                    clr = 1'b1;
    logic                    start = 1'b0;
    logic [LEN_W-1:0]        lenIn = '0;
    logic                    reluEn = 1'b0;
    logic                    inValid = 1'b0;
    logic                    inReady;
    logic [TAPS*ACT_W-1:0]   actIn = '0;
    logic [NCH*TAPS*W_W-1:0] wgtIn = '0;
    logic                    outValid;
    logic                    outReady = 1'b0;
    logic [NCH*OUT_W-1:0]    dutOut;
    logic [NCH-1:0]          satOut;
    logic                    busy;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        int           len;
        logic [51:0]  act;
        logic [63:0]  wgt;
        bit           relu;
        bit           stall;
        int           hold;
        longint       exp0;
        longint       exp1;
        logic [1:0]   expSat;
    } vec_t;

    typedef struct {
        longint     e0;
        longint     e1;
        logic [1:0] s;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    conv_filter_bank #(
        .NCH(NCH), .TAPS(TAPS), .ACT_W(ACT_W), .W_W(W_W), .OUT_W(OUT_W), .LEN_W(LEN_W)
    ) dut (
        .CLK(clk), .CLR(clr), .start(start), .len(lenIn), .relu_en(reluEn),
        .in_valid(inValid), .in_ready(inReady), .act(actIn), .wgt(wgtIn),
        .out_valid(outValid), .out_ready(outReady), .out(dutOut), .sat(satOut), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] packAct(int a0, int a1, int a2, int a3);
        return {13'(a3), 13'(a2), 13'(a1), 13'(a0)};
    endfunction

    function automatic logic [31:0] packW(int w0, int w1, int w2, int w3);
        return {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endfunction

    function automatic longint out0();
        return longint'($signed(dutOut[OUT_W-1:0]));
    endfunction

    function automatic longint out1();
        return longint'($signed(dutOut[2*OUT_W-1:OUT_W]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        int waitCnt;
        string tag;
        tag = $sformatf("vec%0d", idx);
        start  = 1'b1;
        lenIn  = LEN_W'(v.len);
        reluEn = v.relu;
        tick();
        start  = 1'b0;
        reluEn = 1'b0;
        if (v.len != 0) checkOutput({tag, ".inReadyAfterStart"}, longint'(inReady), 1);
        else            checkOutput({tag, ".outValidLenZero"}, longint'(outValid), 1);
        sb.push_back('{e0: v.exp0, e1: v.exp1, s: v.expSat});

        for (int b = 0; b < v.len; b++) begin
            actIn   = v.act;
            wgtIn   = v.wgt;
            inValid = 1'b1;
            tick();
            if (v.stall && b != v.len - 1) begin
                inValid = 1'b0;
                start   = 1'b1;
                lenIn   = LEN_W'(9);
                tick();
                start   = 1'b0;
            end
        end
        inValid = 1'b0;
        checkOutput({tag, ".outValidAfterLast"}, longint'(outValid), 1);

        waitCnt = 0;
        while (!outValid && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        if (!outValid) begin
            checkOutput({tag, ".outValidTimeout"}, 0, 1);
            void'(sb.pop_front());
            return;
        end

        e = sb.pop_front();
        checkOutput({tag, ".out0"}, out0(), e.e0);
        checkOutput({tag, ".out1"}, out1(), e.e1);
        checkOutput({tag, ".sat"}, longint'(satOut), longint'(e.s));

        for (int h = 0; h < v.hold; h++) begin
            start = v.stall;
            lenIn = LEN_W'(9);
            tick();
            start = 1'b0;
            checkOutput({tag, ".holdValid"}, longint'(outValid), 1);
            checkOutput({tag, ".holdOut0"}, out0(), e.e0);
            checkOutput({tag, ".holdOut1"}, out1(), e.e1);
            checkOutput({tag, ".holdSat"}, longint'(satOut), longint'(e.s));
        end

        // A start coinciding with the output handshake must be dropped.
        outReady = 1'b1;
        start    = v.stall;
        tick();
        outReady = 1'b0;
        start    = 1'b0;
        checkOutput({tag, ".validAfterHs"}, longint'(outValid), 0);
        checkOutput({tag, ".busyAfterHs"}, longint'(busy), 0);
        checkOutput({tag, ".idleOut0"}, out0(), e.e0);
        tick();
        checkOutput({tag, ".stillIdle"}, longint'(inReady), 0);
    endtask

    initial begin
        vec_t dotVec;
        dotVec = '{len: 1, act: packAct(1, 2, 3, 4),
                   wgt: {packW(-1, 0, 2, -3), packW(1, 1, 1, 1)},
                   relu: 1'b0, stall: 1'b0, hold: 0, exp0: 10, exp1: -7, expSat: 2'b00};
        vecs[0] = dotVec;
        vecs[1] = dotVec;
        vecs[1].relu = 1'b1;
        vecs[1].exp1 = 0;
        vecs[2] = dotVec;
        vecs[3] = '{len: 3, act: packAct(100, 0, 0, 0),
                    wgt: {packW(0, 0, 0, 0), packW(5, 0, 0, 0)},
                    relu: 1'b0, stall: 1'b1, hold: 4, exp0: 1500, exp1: 0, expSat: 2'b00};
        vecs[4] = '{len: 0, act: packAct(1, 2, 3, 4),
                    wgt: {packW(1, 1, 1, 1), packW(1, 1, 1, 1)},
                    relu: 1'b0, stall: 1'b1, hold: 2, exp0: 0, exp1: 0, expSat: 2'b00};
        vecs[5] = '{len: 2, act: packAct(-4096, 4095, -1, 7),
                    wgt: {packW(2, 2, 2, 2), packW(-128, 127, 3, -2)},
                    relu: 1'b1, stall: 1'b0, hold: 1, exp0: 2088672, exp1: 20, expSat: 2'b00};
        vecs[6] = '{len: 5, act: packAct(10, -20, 30, -40),
                    wgt: {packW(-1, -1, -1, -1), packW(1, 2, 3, 4)},
                    relu: 1'b1, stall: 1'b0, hold: 0, exp0: 0, exp1: 100, expSat: 2'b00};
        vecs[7] = '{len: 300, act: packAct(4095, 4095, 4095, 4095),
                    wgt: {packW(-128, -128, -128, -128), packW(127, 127, 127, 127)},
                    relu: 1'b0, stall: 1'b0, hold: 1, exp0: 2097151, exp1: -2097152, expSat: 2'b11};
        vecs[8] = dotVec;

        tick();
        tick();
        checkOutput("reset.inReady", longint'(inReady), 0);
        checkOutput("reset.outValid", longint'(outValid), 0);
        checkOutput("reset.busy", longint'(busy), 0);
        checkOutput("reset.out", longint'(dutOut), 0);
        checkOutput("reset.sat", longint'(satOut), 0);
        clr = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset asserted between edges after two of four beats.
        start = 1'b1;
        lenIn = LEN_W'(4);
        tick();
        start = 1'b0;
        actIn = packAct(1, 2, 3, 4);
        wgtIn = {packW(127, 127, 127, 127), packW(1, 1, 1, 1)};
        inValid = 1'b1;
        tick();
        tick();
        inValid = 1'b0;
        checkOutput("midRun.busyBeforeReset", longint'(busy), 1);
        #3;
        clr = 1'b1;
        #1;
        checkOutput("midRun.inReady", longint'(inReady), 0);
        checkOutput("midRun.busy", longint'(busy), 0);
        checkOutput("midRun.out", longint'(dutOut), 0);
        checkOutput("midRun.sat", longint'(satOut), 0);
        tick();
        clr = 1'b0;
        tick();
        checkOutput("midRun.idleAfterRelease", longint'(busy), 0);
        applyStimulus(dotVec, 99);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
